inta_sequencer: RTL

//  CPU-side counterpart of intel8259. Converts the 8259 INT line into the two-pulse

---
 rtl/inta_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// CPU-side interrupt acknowledge sequencer for an 8259: runs the two-pulse INTA_n cycle,
// captures the vector for the core, and issues non-specific EOI writes on request.
module inta_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       intr,
    input  logic       if_en,
    output logic [7:0] vec,
    output logic       vec_valid,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       eoi_done,
    output logic       inta_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       busy
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [7:0]    EOI_CMD    = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        VALID,
        EOI_WR,
        EOI_REL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // The counter is reloaded on every state entry and each timed state leaves when it hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            inta_n    <= 1'b1;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            a0        <= 1'b0;
            d_oe      <= 1'b0;
            d_out     <= 8'h00;
            vec       <= 8'h00;
            vec_valid <= 1'b0;
            eoi_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            eoi_done <= 1'b0;
            case (state)
                IDLE: begin
                    // eoi_req is ignored during the eoi_done cycle so a requester dropping it on
                    // eoi_done does not trigger a second write.
                    if (eoi_req && !eoi_done) begin
                        state <= EOI_WR;
                        cnt   <= PULSE_LOAD;
                        cs_n  <= 1'b0;
                        wr_n  <= 1'b0;
                        a0    <= 1'b0;
                        d_oe  <= 1'b1;
                        d_out <= EOI_CMD;
                        busy  <= 1'b1;
                    end else if (intr && if_en) begin
                        state  <= ACK1;
                        cnt    <= PULSE_LOAD;
                        inta_n <= 1'b0;
                        busy   <= 1'b1;
                    end
                end

                ACK1: begin
                    if (cnt == '0) begin
                        state  <= GAP;
                        cnt    <= GAP_LOAD;
                        inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == '0) begin
                        state  <= ACK2;
                        cnt    <= PULSE_LOAD;
                        inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ACK2: begin
                    if (cnt == '0) begin
                        state     <= VALID;
                        cnt       <= '0;
                        inta_n    <= 1'b1;
                        vec       <= d_in;
                        vec_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                VALID: begin
                    if (vec_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                EOI_WR: begin
                    if (cnt == '0) begin
                        state <= EOI_REL;
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Data stays driven one cycle past the write strobe for hold time.
                EOI_REL: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    d_oe     <= 1'b0;
                    d_out    <= 8'h00;
                    eoi_done <= 1'b1;
                    busy     <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    inta_n    <= 1'b1;
                    cs_n      <= 1'b1;
                    wr_n      <= 1'b1;
                    a0        <= 1'b0;
                    d_oe      <= 1'b0;
                    d_out     <= 8'h00;
                    vec_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
